// File: rtl/score_bcd_if.sv
// Handshake bundle between the score counter side and score_bcd_converter.
interface score_bcd_if #(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, output bin, input busy, input done, input bcd, input ovf);
  modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, result held between conversions.
// Optional saturation of bcd to all nines on overflow: define SCORE_BCD_SAT_EN.
module score_bcd_converter #(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  score_bcd_if.slave  bus
);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_val();
    logic [63:0] m;
    m = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_val();

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   adj;
  logic [SR_W-1:0]   sr_next;
  logic [CNT_W-1:0]  count;
  logic              ovf_pending;
  logic              bin_over;

  // Add 3 to every digit >= 5 before the shift; carry out of the top digit falls off the end.
  always_comb begin
    adj = sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (adj[BIN_W + 4*d +: 4] >= 4'd5)
        adj[BIN_W + 4*d +: 4] = adj[BIN_W + 4*d +: 4] + 4'd3;
    end
    sr_next  = adj << 1;
    bin_over = (64'(bus.bin) > MAX_VAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd     <= '0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr          <= {{BCD_W{1'b0}}, bus.bin};
            count       <= '0;
            ovf_pending <= bin_over;
            bus.busy    <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          sr    <= sr_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(BIN_W - 1)) begin
`ifdef SCORE_BCD_SAT_EN
            bus.bcd <= ovf_pending ? {DIGITS{4'h9}} : sr_next[SR_W-1 -: BCD_W];
`else
            bus.bcd <= sr_next[SR_W-1 -: BCD_W];
`endif
            bus.ovf  <= ovf_pending;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed plus randomized checks of score_bcd_converter against a decimal-arithmetic reference model.
module tb_score_bcd_converter;
  localparam int unsigned BIN_W  = 10;
  localparam int unsigned DIGITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  score_bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  score_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of v mod 1000, or all nines when saturating an out-of-range value.
  function automatic logic [11:0] ref_bcd(input int v);
    int m;
    m = v % 1000;
`ifdef SCORE_BCD_SAT_EN
    if (v > 999) return 12'h999;
`endif
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic convert(input int v, input string tag);
    int          lat;
    bit          bad;
    logic [11:0] held;
    held = bus.bcd;
    lat  = -1;
    bad  = 0;
    bus.bin   = 10'(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bin   = 10'($urandom_range(0, 1023));
    chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= int'(BIN_W) + 4 && lat < 0; i++) begin
      tick();
      if (bus.busy && bus.done) bad = 1;
      if (bus.done) lat = i;
      else if (!bus.busy || bus.bcd !== held) bad = 1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(BIN_W));
    chk({tag, "_midconv"}, 32'(bad), 32'd0);
    chk({tag, "_bcd"}, 32'(bus.bcd), 32'(ref_bcd(v)));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(v > 999));
    chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int dones;
    int first_done;
    int d_cyc[$];
    logic [11:0] d_val[$];

    bus.start = 1'b0;
    bus.bin   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd",  32'(bus.bcd),  32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0;
    tick();

    convert(0, "zero");
    convert(999, "max");
    bus.bin = 10'd5;
    repeat (4) tick();
    chk("hold_bcd", 32'(bus.bcd), 32'h999);
    convert(1023, "over");

    // Second start mid-conversion must be ignored.
    bus.bin = 10'd123; bus.start = 1'b1; tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.bin = 10'd456; bus.start = 1'b1; tick();
    bus.start = 1'b0;
    dones = 0; first_done = -1;
    for (int i = 5; i <= 25; i++) begin
      tick();
      if (bus.done) begin
        dones++;
        if (first_done < 0) first_done = i;
      end
    end
    chk("ign_dones", 32'(dones), 32'd1);
    chk("ign_lat", 32'(first_done), 32'(BIN_W));
    chk("ign_bcd", 32'(bus.bcd), 32'h123);

    // Start held high: back-to-back conversions.
    bus.bin = 10'd42; bus.start = 1'b1; tick();
    bus.bin = 10'd7;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (bus.done) begin
        d_cyc.push_back(i);
        d_val.push_back(bus.bcd);
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 32'(d_cyc.size()), 32'd2);
    if (d_cyc.size() == 2) begin
      chk("b2b_first", 32'(d_val[0]), 32'h042);
      chk("b2b_second", 32'(d_val[1]), 32'h007);
      chk("b2b_gap", 32'(d_cyc[1] - d_cyc[0]), 32'(BIN_W + 1));
    end
    for (int i = 0; i < 15 && bus.busy; i++) tick();
    chk("b2b_idle", 32'(bus.busy), 32'd0);
    tick();

    // Reset mid-conversion aborts without a done pulse.
    convert(321, "pre_rst");
    bus.bin = 10'd500; bus.start = 1'b1; tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bcd",  32'(bus.bcd),  32'd0);
    chk("abort_ovf",  32'(bus.ovf),  32'd0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    chk("abort_quiet", 32'(dones), 32'd0);
    convert(777, "post_rst");

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      convert(int'($urandom_range(0, 1023)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
